instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the 9-bit SIAA core.
- Owns the program counter and steps each instruction through FETCH, DECODE, EXEC/MEM/WB.
- Consumes the control decoder's outputs (regWrite, regSet, memRead, memWrite, branch) and the fetched instruction.
- Drives one-cycle write strobes to the register file, a req/ready handshake to data memory, and halts on terminate.

Parameters:
PC_W, 10, program counter / instruction memory address width
START_PC, 0, PC value loaded on reset and on start
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ready before error halt

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  pulse; begins execution from START_PC (IDLE/HALT only)
inst  in  9  instruction from instruction memory at pc
reg_write  in  1  decoder: write R0
reg_set  in  1  decoder: write general register (set)
mem_read  in  1  decoder: lw
mem_write  in  1  decoder: sw
branch  in  1  decoder: br or j
branch_cond  in  1  br condition (R0 != 0), from datapath
branch_target  in  PC_W  target address from branch LUT
mem_ready  in  1  data memory acknowledge
pc  out  PC_W  program counter
ir_en  out  1  latch instruction register
rf_we  out  1  R0 write strobe
rf_set_we  out  1  general-register write strobe
dm_req  out  1  data memory request
dm_we  out  1  data memory write (valid with dm_req)
busy  out  1  high in FETCH..WB
done  out  1  high in HALT
err  out  1  sticky timeout flag
instr_count  out  16  retired instructions, saturating

Behaviour:
- Reset (async): state=IDLE, pc=START_PC, instr_count=0, err=0; all strobes 0, busy=0, done=0.
- State register, pc, counters and err are registered; strobes are Moore outputs decoded from state plus registered decoder bits.
- IDLE: start -> FETCH, pc=START_PC, instr_count=0, err=0.
- FETCH: ir_en=1 for one cycle -> DECODE.
- DECODE: capture decoder bits.
  - Terminate (inst[8]=1, inst[2:0]=6) -> HALT; pc unchanged; not counted.
  - mem_read|mem_write -> MEM.
  - Otherwise -> EXEC.
- EXEC, one cycle:
  - rf_we=reg_write, rf_set_we=reg_set.
  - pc update:
    - pc = branch_target if branch and (j, i.e. inst[8]=0 and inst[3:0]=13, or branch_cond).
    - Otherwise pc = pc+1.
  - Undefined I-op 7 executes as a NOP.
  - Next state FETCH.
- MEM:
  - dm_req=1, dm_we=mem_write; held stable until mem_ready is sampled high.
  - On mem_ready:
    - lw -> WB.
    - sw -> pc=pc+1, FETCH.
  - mem_ready already high on first MEM cycle completes in that cycle.
  - Wait counter counts MEM cycles without mem_ready; reaching MEM_TIMEOUT -> HALT, err=1.
- WB: rf_we=1 for one cycle, pc=pc+1 -> FETCH.
- Latency:
  - ALU/set/branch: 3 cycles.
  - sw: 2+n cycles; lw: 3+n cycles (n = MEM cycles, at least 1).
- pc+1 wraps modulo 2^PC_W (max -> 0), no flag.
- instr_count increments on every transition into FETCH from EXEC/MEM/WB; saturates at 0xFFFF.
- HALT: done=1, busy=0, pc frozen. start -> FETCH from START_PC; clears done, err, instr_count.
- start while busy is ignored.
- reset mid-instruction (including mid-MEM): immediate return to IDLE; dm_req drops asynchronously; no write strobe is emitted.
- rf_we and dm_req are never asserted in the same cycle.

Decomposition:
- Shared package siaa_pkg:
  - State enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT).
  - Opcode constants: R_J=13, R_BR=12, R_LW=8, R_SW=9, I_TERM=6.
  - Instruction field slices.
- One natural sub-module, mem_wait_timer: loadable down-counter with expire output, cleared on MEM entry.

Test Plan:
- reset, start, inst=0x000 (add, reg_write=1) -> ir_en @cycle1, rf_we @cycle3, pc 0->1, instr_count=1.
- lw with mem_ready delayed 2 cycles -> dm_req high 3 cycles, dm_we=0, rf_we one cycle after ready, pc+1.
- br with branch_cond=0 then 1, branch_target=0x2A -> pc+1, then pc=0x2A. j with branch_cond=0 -> pc=target.
- pc=0x3FF, add -> pc=0x000. inst=0x106 (terminate) -> done=1, busy=0, pc held, count unchanged. start -> restart at 0.
- sw, mem_ready never asserted -> HALT after 15 MEM cycles, err=1, done=1, dm_req deasserted.
- reset pulse mid-MEM -> dm_req=0 same cycle, state IDLE, pc=0, no rf_we.

Source files
------------

// File: rtl/siaa_pkg.sv
// Shared types and instruction-field helpers for the 9-bit SIAA core.
// R-type opcodes live in inst[3:0] (inst[8]=0); I-type opcodes in inst[2:0] (inst[8]=1).
package siaa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] R_J    = 4'd13;
    localparam logic [3:0] R_BR   = 4'd12;
    localparam logic [3:0] R_LW   = 4'd8;
    localparam logic [3:0] R_SW   = 4'd9;
    localparam logic [2:0] I_TERM = 3'd6;

    function automatic logic is_itype(input logic [8:0] inst);
        return inst[8];
    endfunction

    function automatic logic [3:0] r_op(input logic [8:0] inst);
        return inst[3:0];
    endfunction

    function automatic logic [2:0] i_op(input logic [8:0] inst);
        return inst[2:0];
    endfunction

    function automatic logic is_terminate(input logic [8:0] inst);
        return is_itype(inst) && (i_op(inst) == I_TERM);
    endfunction

    function automatic logic is_jump(input logic [8:0] inst);
        return !is_itype(inst) && (r_op(inst) == R_J);
    endfunction

    function automatic logic is_br(input logic [8:0] inst);
        return !is_itype(inst) && (r_op(inst) == R_BR);
    endfunction

    function automatic logic is_lw(input logic [8:0] inst);
        return !is_itype(inst) && (r_op(inst) == R_LW);
    endfunction

    function automatic logic is_sw(input logic [8:0] inst);
        return !is_itype(inst) && (r_op(inst) == R_SW);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Down-counter bounding how long MEM waits for mem_ready.
// Loaded on MEM entry; expire is the terminal-count compare at zero.
module mem_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC-MEM-WB sequencer for the SIAA core.
// Owns the pc, retire counter and timeout flag; all strobes are registered from next state.
module instr_sequencer
    import siaa_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int START_PC    = 0,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [8:0]      inst,
    input  logic            reg_write,
    input  logic            reg_set,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            branch,
    input  logic            branch_cond,
    input  logic [PC_W-1:0] branch_target,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic            ir_en,
    output logic            rf_we,
    output logic            rf_set_we,
    output logic            dm_req,
    output logic            dm_we,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [15:0]     instr_count
);

    localparam int              TMR_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [PC_W-1:0] PC_START = PC_W'(START_PC);
    localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);

    state_t state, state_n;
    logic   mem_read_q, mem_write_q, branch_q, jump_q;
    logic   tmr_load, tmr_dec, tmr_expire;
    logic   take_branch, mem_write_sel, count_retire;
    logic   unused_inst;

    assign unused_inst = ^inst[7:4];

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_HALT: if (start) state_n = S_FETCH;
            S_FETCH:        state_n = S_DECODE;
            S_DECODE: begin
                if (is_terminate(inst))          state_n = S_HALT;
                else if (mem_read || mem_write)  state_n = S_MEM;
                else                             state_n = S_EXEC;
            end
            S_EXEC:         state_n = S_FETCH;
            S_MEM: begin
                if (mem_ready)       state_n = mem_read_q ? S_WB : S_FETCH;
                else if (tmr_expire) state_n = S_HALT;
            end
            S_WB:           state_n = S_FETCH;
            default:        state_n = S_IDLE;
        endcase
    end

    assign tmr_load      = (state == S_DECODE) && (state_n == S_MEM);
    assign tmr_dec       = (state == S_MEM) && !mem_ready;
    assign take_branch   = branch_q && (jump_q || branch_cond);
    // dm_we is registered on MEM entry, before the decoder bits are captured
    assign mem_write_sel = (state == S_DECODE) ? mem_write : mem_write_q;
    assign count_retire  = (state_n == S_FETCH) &&
                           ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));

    mem_wait_timer #(.W(TMR_W)) u_mem_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (TMR_LOAD),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= PC_START;
            instr_count <= '0;
            err         <= 1'b0;
            ir_en       <= 1'b0;
            rf_we       <= 1'b0;
            rf_set_we   <= 1'b0;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
        end else begin
            state     <= state_n;
            ir_en     <= (state_n == S_FETCH);
            busy      <= (state_n != S_IDLE) && (state_n != S_HALT);
            done      <= (state_n == S_HALT);
            rf_we     <= ((state_n == S_EXEC) && reg_write) || (state_n == S_WB);
            rf_set_we <= (state_n == S_EXEC) && reg_set;
            dm_req    <= (state_n == S_MEM);
            dm_we     <= (state_n == S_MEM) && mem_write_sel;

            if (state == S_DECODE) begin
                mem_read_q  <= mem_read;
                mem_write_q <= mem_write;
                branch_q    <= branch;
                jump_q      <= is_jump(inst);
            end

            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc          <= PC_START;
                        instr_count <= '0;
                        err         <= 1'b0;
                    end
                end
                S_EXEC: pc <= take_branch ? branch_target : pc + PC_ONE;
                S_MEM: begin
                    if (mem_ready && !mem_read_q) pc  <= pc + PC_ONE;
                    else if (!mem_ready && tmr_expire) err <= 1'b1;
                end
                S_WB:   pc <= pc + PC_ONE;
                default: ;
            endcase

            if (count_retire && (instr_count != 16'hFFFF)) begin
                instr_count <= instr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the driver predicts each instruction's
// outcome from the instruction rules; a monitor measures what the DUT did and compares.
module tb_instr_sequencer;

    typedef struct {
        int pc; int cnt; int rf; int rf_at; int rfs;
        int req; int we; int cyc; int halt; int err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, start, reg_write, reg_set, mem_read, mem_write, branch, branch_cond, mem_ready;
    logic [8:0] inst;
    logic [9:0] branch_target;
    logic [9:0] pc;
    logic       ir_en, rf_we, rf_set_we, dm_req, dm_we, busy, done, err;
    logic [15:0] instr_count;

    instr_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .inst(inst),
        .reg_write(reg_write), .reg_set(reg_set), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .branch_cond(branch_cond), .branch_target(branch_target),
        .mem_ready(mem_ready), .pc(pc), .ir_en(ir_en), .rf_we(rf_we), .rf_set_we(rf_set_we),
        .dm_req(dm_req), .dm_we(dm_we), .busy(busy), .done(done), .err(err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_pass = 0;
    exp_t  sb[$];
    string nm_q[$];
    int    m_pc = 0;
    int    m_cnt = 0;
    int    mem_n = 0;

    bit active = 0;
    int o_cyc, o_rf, o_rf_at, o_rfs, o_req, o_we, o_ovl;

    task automatic chk(input string what, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", what, act, exp);
    endtask

    task automatic close_rec();
        exp_t  e;
        string nm;
        if (sb.size() == 0) begin
            chk("unexpected retire", 1, 0);
        end else begin
            e  = sb.pop_front();
            nm = nm_q.pop_front();
            chk({nm, " pc"},        int'(pc), e.pc);
            chk({nm, " count"},     int'(instr_count), e.cnt);
            chk({nm, " rf_we"},     o_rf, e.rf);
            chk({nm, " rf_we at"},  o_rf_at, e.rf_at);
            chk({nm, " rf_set_we"}, o_rfs, e.rfs);
            chk({nm, " dm_req"},    o_req, e.req);
            chk({nm, " dm_we"},     o_we, e.we);
            chk({nm, " cycles"},    o_cyc, e.cyc);
            chk({nm, " done"},      int'(done), e.halt);
            chk({nm, " busy"},      int'(busy), 1 - e.halt);
            chk({nm, " err"},       int'(err), e.err);
            chk({nm, " rf/dm overlap"}, o_ovl, 0);
        end
        active = 0;
    endtask

    // monitor: one record per instruction, from its FETCH to the next FETCH or HALT
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 0;
            end else if (ir_en) begin
                if (active) close_rec();
                active = 1;
                o_cyc = 1; o_rf = 0; o_rf_at = 0; o_rfs = 0; o_req = 0; o_we = 0; o_ovl = 0;
            end else if (active) begin
                if (done) begin
                    close_rec();
                end else begin
                    o_cyc++;
                    if (rf_we) begin o_rf++; o_rf_at = o_cyc; end
                    if (rf_set_we) o_rfs++;
                    if (dm_req) o_req++;
                    if (dm_req && dm_we) o_we++;
                    if (rf_we && dm_req) o_ovl = 1;
                end
            end
        end
    end

    // data memory responder: acknowledge on the mem_n-th request cycle (0 = never)
    initial begin
        int rcnt;
        rcnt = 0;
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (dm_req) begin
                rcnt++;
                mem_ready = (mem_n != 0) && (rcnt == mem_n);
            end else begin
                rcnt = 0;
                mem_ready = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_fetch(input string nm);
        for (int k = 0; k < 100 && !ir_en; k++) @(negedge clk);
        if (!ir_en) chk({nm, " fetch wait"}, 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_pc  = 0;
        m_cnt = 0;
    endtask

    task automatic issue(input string nm, input logic [8:0] i, input bit rw, input bit rs,
                         input bit mr, input bit mw, input bit br, input bit cond,
                         input logic [9:0] tgt, input int nready, input bit poke);
        exp_t e;
        bit   term, jmp, taken;
        wait_fetch(nm);
        inst = i; reg_write = rw; reg_set = rs; mem_read = mr; mem_write = mw;
        branch = br; branch_cond = cond; branch_target = tgt; mem_n = nready; start = poke;

        e = '{pc: m_pc, cnt: m_cnt, rf: 0, rf_at: 0, rfs: 0, req: 0, we: 0, cyc: 0, halt: 0, err: 0};
        term = i[8] && (i[2:0] == 3'd6);
        jmp  = !i[8] && (i[3:0] == 4'd13);
        if (term) begin
            e.cyc = 2; e.halt = 1;
        end else if (mr || mw) begin
            if (nready == 0 || nready > 15) begin
                e.req = 15; e.we = mw ? 15 : 0; e.cyc = 2 + 15; e.halt = 1; e.err = 1;
            end else begin
                e.req = nready; e.we = mw ? nready : 0;
                e.pc  = (m_pc + 1) % 1024;
                e.cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                if (mr) begin e.rf = 1; e.rf_at = 3 + nready; e.cyc = 3 + nready; end
                else    e.cyc = 2 + nready;
            end
        end else begin
            taken = br && (jmp || cond);
            e.pc  = taken ? int'(tgt) : (m_pc + 1) % 1024;
            e.cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            e.rf  = rw; e.rf_at = rw ? 3 : 0; e.rfs = rs; e.cyc = 3;
        end
        sb.push_back(e);
        nm_q.push_back(nm);
        m_pc  = e.pc;
        m_cnt = e.cnt;

        @(negedge clk);
        start = 1'b0;
        if (e.halt) begin
            for (int k = 0; k < 60 && !done; k++) @(negedge clk);
            if (!done) chk({nm, " halt wait"}, 0, 1);
            pulse_start();
        end
    endtask

    task automatic reset_mid_mem();
        wait_fetch("reset mid-mem");
        inst = 9'h009; reg_write = 0; reg_set = 0; mem_read = 0; mem_write = 1;
        branch = 0; branch_cond = 0; mem_n = 0;
        repeat (4) @(negedge clk);
        chk("mid-mem dm_req before reset", int'(dm_req), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid-mem reset dm_req", int'(dm_req), 0);
        chk("mid-mem reset busy",   int'(busy), 0);
        chk("mid-mem reset pc",     int'(pc), 0);
        chk("mid-mem reset rf_we",  int'(rf_we), 0);
        chk("mid-mem reset count",  int'(instr_count), 0);
        chk("mid-mem reset done",   int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_write = 0;
        @(negedge clk);
        chk("idle after reset busy", int'(busy), 0);
        chk("idle after reset rf_we", int'(rf_we), 0);
        pulse_start();
    endtask

    initial begin
        reset = 1'b1; start = 0; inst = '0; reg_write = 0; reg_set = 0; mem_read = 0;
        mem_write = 0; branch = 0; branch_cond = 0; branch_target = '0;
        repeat (3) @(negedge clk);
        chk("reset pc", int'(pc), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        chk("reset count", int'(instr_count), 0);
        chk("reset strobes", int'({ir_en, rf_we, rf_set_we, dm_req, dm_we}), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle stays idle", int'(busy), 0);
        pulse_start();

        issue("add",        9'h000, 1, 0, 0, 0, 0, 0, 10'h000, 0, 0);
        issue("lw ready3",  9'h008, 0, 0, 1, 0, 0, 0, 10'h000, 3, 0);
        issue("br nt",      9'h00C, 0, 0, 0, 0, 1, 0, 10'h02A, 0, 0);
        issue("br t",       9'h00C, 0, 0, 0, 0, 1, 1, 10'h02A, 0, 0);
        issue("j",          9'h00D, 0, 0, 0, 0, 1, 0, 10'h3FF, 0, 0);
        issue("add wrap",   9'h001, 1, 0, 0, 0, 0, 0, 10'h000, 0, 1);
        issue("set",        9'h105, 0, 1, 0, 0, 0, 0, 10'h000, 0, 0);
        issue("iop7 nop",   9'h107, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0);
        issue("sw ready1",  9'h009, 0, 0, 0, 1, 0, 0, 10'h000, 1, 0);
        issue("terminate",  9'h106, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0);
        issue("add restart", 9'h002, 1, 0, 0, 0, 0, 0, 10'h000, 0, 0);
        issue("sw timeout", 9'h009, 0, 0, 0, 1, 0, 0, 10'h000, 0, 0);
        issue("lw ready1",  9'h008, 0, 0, 1, 0, 0, 0, 10'h000, 1, 0);

        for (int r = 0; r < 60; r++) begin
            int         kind;
            logic [3:0] hi;
            logic [9:0] tgt;
            bit         cond, poke, rb;
            kind = $urandom_range(0, 6);
            hi   = 4'($urandom);
            tgt  = 10'($urandom);
            cond = 1'($urandom);
            rb   = 1'($urandom);
            poke = ($urandom_range(0, 3) == 0);
            case (kind)
                0: issue("rnd alu", {1'b0, hi, 4'($urandom_range(0, 11))}, rb, 0, 0, 0, 0, cond, tgt, 0, poke);
                1: issue("rnd set", {1'b1, hi, 1'b0, 3'($urandom_range(0, 5))}, 0, rb, 0, 0, 0, cond, tgt, 0, poke);
                2: issue("rnd br",  {1'b0, hi, 4'd12}, 0, 0, 0, 0, 1, cond, tgt, 0, poke);
                3: issue("rnd j",   {1'b0, hi, 4'd13}, 0, 0, 0, 0, 1, cond, tgt, 0, poke);
                4: issue("rnd lw",  {1'b0, hi, 4'd8}, 0, 0, 1, 0, 0, cond, tgt, $urandom_range(1, 4), poke);
                5: issue("rnd sw",  {1'b0, hi, 4'd9}, 0, 0, 0, 1, 0, cond, tgt, $urandom_range(1, 4), poke);
                default: begin
                    if ($urandom_range(0, 3) == 0)
                        issue("rnd term", {1'b1, hi, 4'd6}, 0, 0, 0, 0, 0, cond, tgt, 0, 0);
                    else
                        issue("rnd nop", {1'b1, hi, 4'd7}, 0, 0, 0, 0, 0, cond, tgt, 0, poke);
                end
            endcase
        end

        reset_mid_mem();
        issue("add after reset", 9'h003, 1, 0, 0, 0, 0, 0, 10'h000, 0, 0);

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
